// File: rtl/wb_as_master_pkg.sv
// wb_as_master_pkg: command/response codes and FSM encoding shared by the AS master, responder and benches
package wb_as_master_pkg;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RESP_ACK  = 8'h01;
  typedef enum logic [3:0] {
    IDLE, TX_CMD, TX_ADRL, TX_ADRH, TX_DATL, TX_DATH, RX_ACK, RX_DATL, RX_DATH, DONE
  } state_t;
endpackage

// File: rtl/wb_as_master.sv
// wb_as_master: Wishbone slave that serialises each access into AS command bytes and collects the response
module wb_as_master
  import wb_as_master_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  as_data_o,
  output logic        as_dstrb_o,
  input  logic        as_busy_i,
  input  logic [7:0]  as_data_i,
  input  logic        as_dstrb_i,
  output logic        as_busy_o
);
  state_t      state, state_nx;
  logic        we, live;
  logic [15:0] adr, dat, cnt;
  logic [7:0]  lo;
  logic        tx_st, rx_st, tx_xfer, rx_xfer, timeout, req, bad;
  assign tx_st   = state inside {TX_CMD, TX_ADRL, TX_ADRH, TX_DATL, TX_DATH};
  assign rx_st   = state inside {RX_ACK, RX_DATL, RX_DATH};
  assign tx_xfer = as_dstrb_o & ~as_busy_i;
  assign rx_xfer = as_dstrb_i & ~as_busy_o;
  assign timeout = rx_st & ~rx_xfer & (cnt == 16'(TIMEOUT - 1));
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign bad     = (state == RX_ACK) & rx_xfer & (as_data_i != RESP_ACK);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? TX_CMD : IDLE;
      TX_CMD:  state_nx = tx_xfer ? TX_ADRL : TX_CMD;
      TX_ADRL: state_nx = tx_xfer ? TX_ADRH : TX_ADRL;
      TX_ADRH: state_nx = tx_xfer ? (we ? TX_DATL : RX_ACK) : TX_ADRH;
      TX_DATL: state_nx = tx_xfer ? TX_DATH : TX_DATL;
      TX_DATH: state_nx = tx_xfer ? RX_ACK : TX_DATH;
      RX_ACK:  state_nx = rx_xfer ? (bad ? IDLE : we ? DONE : RX_DATL) : timeout ? IDLE : RX_ACK;
      RX_DATL: state_nx = rx_xfer ? RX_DATH : timeout ? IDLE : RX_DATL;
      RX_DATH: state_nx = rx_xfer ? DONE : timeout ? IDLE : RX_DATH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    as_dstrb_o = tx_st;
    as_busy_o  = ~rx_st;
    wb_ack_o   = (state == DONE) & live;
    as_data_o  = state == TX_CMD  ? (we ? CMD_WRITE : CMD_READ) :
                 state == TX_ADRL ? adr[7:0]  :
                 state == TX_ADRH ? adr[15:8] :
                 state == TX_DATL ? dat[7:0]  :
                 state == TX_DATH ? dat[15:8] : 8'h00;
  end
  // live tracks whether the Wishbone master is still waiting; once cyc drops the pulse is swallowed
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we       <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      lo       <= '0;
      wb_dat_o <= '0;
      cnt      <= '0;
      wb_err_o <= 1'b0;
      live     <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        we   <= wb_we_i;
        adr  <= wb_adr_i;
        dat  <= wb_dat_i;
        live <= 1'b1;
      end else live <= live & wb_cyc_i;
      if (state == RX_DATL && rx_xfer) lo <= as_data_i;
      if (state == RX_DATH && rx_xfer) wb_dat_o <= {as_data_i, lo};
      cnt      <= (rx_st && !rx_xfer) ? cnt + 16'd1 : '0;
      wb_err_o <= (bad | timeout) & live & wb_cyc_i;
    end
endmodule

// File: tb/tb_wb_as_master.sv
// tb_wb_as_master: scoreboard bench; stimulus queues expected AS bytes and completions, a monitor checks them
module tb_wb_as_master;
  import wb_as_master_pkg::*;
  localparam int K_TX = 0, K_ACK = 1, K_ERR = 2;
  typedef struct {int kind; logic [15:0] val; bit chk;} exp_t;
  logic        clk = 0, reset = 1;
  logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [15:0] wb_adr_i = 0, wb_dat_i = 0, wb_dat_o;
  logic        wb_ack_o, wb_err_o, as_dstrb_o, as_busy_o;
  logic [7:0]  as_data_o, as_data_i = 0;
  logic        as_busy_i = 0, as_dstrb_i = 0;
  bit          busy_mode = 0;
  int          vectors = 0, miscompares = 0, tx_seen = 0;
  exp_t        q[$];
  wb_as_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .as_data_o(as_data_o), .as_dstrb_o(as_dstrb_o), .as_busy_i(as_busy_i),
    .as_data_i(as_data_i), .as_dstrb_i(as_dstrb_i), .as_busy_o(as_busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  task automatic push(input int kind, input logic [15:0] val, input bit c);
    exp_t e;
    e.kind = kind; e.val = val; e.chk = c;
    q.push_back(e);
  endtask
  task automatic pop_chk(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected event: got kind %0d, expected nothing", kind);
      return;
    end
    e = q.pop_front();
    chk("event kind", 16'(kind), 16'(e.kind));
    if (kind == K_TX) chk("tx byte", 16'(as_data_o), e.val);
    if (kind == K_ACK && e.chk) chk("read data", wb_dat_o, e.val);
  endtask
  // monitor: everything the DUT presents is matched against the scoreboard queue
  always @(negedge clk) if (!reset) begin
    if (wb_ack_o && wb_err_o) chk("ack and err together", 16'd1, 16'd0);
    if (as_dstrb_o && as_busy_i) begin
      if (q.size() == 0) chk("held byte with empty queue", 16'd1, 16'd0);
      else chk("held byte stable", 16'(as_data_o), q[0].val);
    end
    if (as_dstrb_o && !as_busy_i) begin
      pop_chk(K_TX);
      tx_seen++;
    end
    if (wb_ack_o) pop_chk(K_ACK);
    if (wb_err_o) pop_chk(K_ERR);
  end
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      as_busy_i = busy_mode ? (ph != 3) : 1'b0;
      ph = busy_mode ? (ph + 1) % 4 : 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk_reset_vals();
    chk("rst as_dstrb_o", 16'(as_dstrb_o), 16'd0);
    chk("rst as_data_o", 16'(as_data_o), 16'h00);
    chk("rst as_busy_o", 16'(as_busy_o), 16'd1);
    chk("rst wb_ack_o", 16'(wb_ack_o), 16'd0);
    chk("rst wb_err_o", 16'(wb_err_o), 16'd0);
    chk("rst wb_dat_o", wb_dat_o, 16'h0000);
  endtask
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wb_we_i = w; wb_adr_i = a; wb_dat_i = d; wb_cyc_i = 1; wb_stb_i = 1;
    push(K_TX, w ? 16'(CMD_WRITE) : 16'(CMD_READ), 0);
    push(K_TX, 16'(a[7:0]), 0);
    push(K_TX, 16'(a[15:8]), 0);
    if (w) begin
      push(K_TX, 16'(d[7:0]), 0);
      push(K_TX, 16'(d[15:8]), 0);
    end
  endtask
  task automatic respond(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (as_busy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("responder ready timeout", 16'(as_busy_o), 16'd0);
    as_dstrb_i = 1; as_data_i = b;
    @(posedge clk); #1;
    as_dstrb_i = 0;
  endtask
  task automatic end_ok();
    @(negedge clk);
    chk("ack one clk after last byte", 16'(wb_ack_o), 16'd1);
    chk("err low on success", 16'(wb_err_o), 16'd0);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    chk("ack single cycle", 16'(wb_ack_o), 16'd0);
  endtask
  task automatic end_err();
    @(negedge clk);
    chk("err after bad response", 16'(wb_err_o), 16'd1);
    chk("no ack on error", 16'(wb_ack_o), 16'd0);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    chk("err single cycle", 16'(wb_err_o), 16'd0);
    chk("idle after error", 16'(as_busy_o | as_dstrb_o << 1), 16'd1);
  endtask
  initial begin
    int t, n, base;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 0;
    req(1, 16'h0005, 16'hFFFA);
    push(K_ACK, 16'h0000, 0);
    respond(RESP_ACK);
    end_ok();
    req(0, 16'h0003, 16'h0000);
    push(K_ACK, 16'hFFFC, 1);
    respond(RESP_ACK);
    respond(8'hFC);
    respond(8'hFF);
    end_ok();
    chk("wb_dat_o holds", wb_dat_o, 16'hFFFC);
    busy_mode = 1;
    req(1, 16'h0005, 16'hFFFA);
    push(K_ACK, 16'h0000, 0);
    respond(RESP_ACK);
    end_ok();
    busy_mode = 0;
    req(0, 16'h0009, 16'h0000);
    push(K_ERR, 16'h0000, 0);
    respond(8'h00);
    end_err();
    req(0, 16'h0007, 16'h0000);
    push(K_ERR, 16'h0000, 0);
    t = 0;
    @(negedge clk);
    while (as_busy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (!wb_err_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout cycles from RX_ACK entry", 16'(n), 16'd16);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    chk("timeout err single cycle", 16'(wb_err_o), 16'd0);
    req(1, 16'h1234, 16'hBEEF);
    push(K_ACK, 16'h0000, 0);
    base = tx_seen; t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (tx_seen < base + 2 && t < 50);
    #2 reset = 1;
    #1 chk_reset_vals();
    q.delete();
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    req(1, 16'h00A0, 16'h5555);
    push(K_ACK, 16'h0000, 0);
    respond(RESP_ACK);
    end_ok();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
